// File: rtl/sram_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_initiator
// Function : RTAP-side master that serialises one SRAM BIST read/write request
//            onto the broadcast nibble bus and collects the read-back nibbles.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bist_initiator #(
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [7:0]   req_sram_id,
    input  logic [7:0]   req_chunk_id,
    input  logic [15:0]  req_addr,
    input  logic [319:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [383:0] rsp_rdata,
    output logic [2:0]   rtap_srams_bist_command,
    output logic [3:0]   rtap_srams_bist_data,
    input  logic [3:0]   srams_rtap_data
);

    localparam logic [2:0] OP_NOP           = 3'd0;
    localparam logic [2:0] OP_SHIFT_ID      = 3'd1;
    localparam logic [2:0] OP_SHIFT_BSEL    = 3'd2;
    localparam logic [2:0] OP_SHIFT_ADDRESS = 3'd3;
    localparam logic [2:0] OP_READ          = 3'd4;
    localparam logic [2:0] OP_SHIFT_DATA    = 3'd5;

    // The responder needs at least two idle cycles to write and commit the word.
    localparam int         GAP_EFF  = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
    localparam logic [6:0] GAP_LAST = 7'(GAP_EFF - 1);
    localparam logic [6:0] RD_LAST  = 7'd95;
    localparam logic [6:0] WR_LAST  = 7'd78;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_BSEL,
        ST_ADDR,
        ST_OP,
        ST_RD_WAIT,
        ST_RD_SHIFT,
        ST_WR_SHIFT,
        ST_GAP,
        ST_RSP
    } state_t;

    state_t         state_q;
    logic [6:0]     cnt_q;
    logic           write_q;
    logic [31:0]    hdr_q;
    logic [319:0]   wd_q;
    logic [383:0]   rdata_q;
    logic           rsp_valid_q;
    logic [2:0]     cmd_q;
    logic [3:0]     data_q;

    // Bus values are registered alongside the state they belong to, so every
    // transition below also loads the command/nibble for the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 7'd0;
            write_q     <= 1'b0;
            hdr_q       <= 32'h0;
            wd_q        <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            cmd_q       <= OP_NOP;
            data_q      <= 4'h0;
        end else begin
            cmd_q  <= OP_NOP;
            data_q <= 4'h0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        hdr_q   <= {req_sram_id[3:0], req_chunk_id, req_addr, 4'h0};
                        wd_q    <= req_wdata;
                        rdata_q <= '0;
                        state_q <= ST_ID;
                        cnt_q   <= 7'd0;
                        cmd_q   <= OP_SHIFT_ID;
                        data_q  <= req_sram_id[7:4];
                    end
                end
                ST_ID: begin
                    data_q <= hdr_q[31:28];
                    hdr_q  <= {hdr_q[27:0], 4'h0};
                    if (cnt_q == 7'd0) begin
                        cnt_q <= 7'd1;
                        cmd_q <= OP_SHIFT_ID;
                    end else begin
                        state_q <= ST_BSEL;
                        cnt_q   <= 7'd0;
                        cmd_q   <= OP_SHIFT_BSEL;
                    end
                end
                ST_BSEL: begin
                    data_q <= hdr_q[31:28];
                    hdr_q  <= {hdr_q[27:0], 4'h0};
                    if (cnt_q == 7'd0) begin
                        cnt_q <= 7'd1;
                        cmd_q <= OP_SHIFT_BSEL;
                    end else begin
                        state_q <= ST_ADDR;
                        cnt_q   <= 7'd0;
                        cmd_q   <= OP_SHIFT_ADDRESS;
                    end
                end
                ST_ADDR: begin
                    if (cnt_q != 7'd3) begin
                        cnt_q  <= cnt_q + 7'd1;
                        cmd_q  <= OP_SHIFT_ADDRESS;
                        data_q <= hdr_q[31:28];
                        hdr_q  <= {hdr_q[27:0], 4'h0};
                    end else begin
                        state_q <= ST_OP;
                        cnt_q   <= 7'd0;
                        if (write_q) begin
                            cmd_q  <= OP_SHIFT_DATA;
                            data_q <= wd_q[319:316];
                            wd_q   <= {wd_q[315:0], 4'h0};
                        end else begin
                            cmd_q <= OP_READ;
                        end
                    end
                end
                ST_OP: begin
                    if (write_q) begin
                        state_q <= ST_WR_SHIFT;
                        cmd_q   <= OP_SHIFT_DATA;
                        data_q  <= wd_q[319:316];
                        wd_q    <= {wd_q[315:0], 4'h0};
                    end else begin
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    state_q <= ST_RD_SHIFT;
                    cnt_q   <= 7'd0;
                    cmd_q   <= OP_SHIFT_DATA;
                end
                ST_RD_SHIFT: begin
                    // Responder drives its nibble during the SHIFT_DATA cycle itself.
                    rdata_q <= {rdata_q[379:0], srams_rtap_data};
                    if (cnt_q == RD_LAST) begin
                        state_q <= ST_GAP;
                        cnt_q   <= 7'd0;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                        cmd_q <= OP_SHIFT_DATA;
                    end
                end
                ST_WR_SHIFT: begin
                    if (cnt_q == WR_LAST) begin
                        state_q <= ST_GAP;
                        cnt_q   <= 7'd0;
                    end else begin
                        cnt_q  <= cnt_q + 7'd1;
                        cmd_q  <= OP_SHIFT_DATA;
                        data_q <= wd_q[319:316];
                        wd_q   <= {wd_q[315:0], 4'h0};
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q     <= ST_RSP;
                        cnt_q       <= 7'd0;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 7'd0;
                end
            endcase
        end
    end

    assign req_ready               = (state_q == ST_IDLE);
    assign rsp_valid               = rsp_valid_q;
    assign rsp_rdata               = rdata_q;
    assign rtap_srams_bist_command = cmd_q;
    assign rtap_srams_bist_data    = data_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bist_initiator
// Function : Self-checking bench with a behavioural SRAM wrapper and a
//            reference memory for sram_bist_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bist_initiator;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ID   = 3'd1;
    localparam logic [2:0] C_BSEL = 3'd2;
    localparam logic [2:0] C_ADDR = 3'd3;
    localparam logic [2:0] C_READ = 3'd4;
    localparam logic [2:0] C_DATA = 3'd5;
    localparam logic [7:0] MY_ID  = 8'h2A;
    localparam logic [7:0] MY_CH  = 8'h01;
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RD   = 2'd1;
    localparam logic [1:0] M_WR   = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_valid_g0 = 1'b0;
    logic         req_valid_g5 = 1'b0;
    logic         req_write = 1'b0;
    logic [7:0]   req_sram_id = 8'h0;
    logic [7:0]   req_chunk_id = 8'h0;
    logic [15:0]  req_addr = 16'h0;
    logic [319:0] req_wdata = '0;
    logic         rsp_ready = 1'b0;

    logic         req_ready, rsp_valid;
    logic [383:0] rsp_rdata;
    logic [2:0]   dut_cmd;
    logic [3:0]   dut_data;
    logic [3:0]   srams_rtap_data;

    logic         g0_req_ready, g0_rsp_valid, g5_req_ready, g5_rsp_valid;
    logic [383:0] g0_rsp_rdata, g5_rsp_rdata;
    logic [2:0]   g0_cmd, g5_cmd;
    logic [3:0]   g0_data, g5_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_bist_initiator #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_sram_id(req_sram_id), .req_chunk_id(req_chunk_id),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rtap_srams_bist_command(dut_cmd), .rtap_srams_bist_data(dut_data),
        .srams_rtap_data(srams_rtap_data)
    );

    sram_bist_initiator #(.GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_g0), .req_ready(g0_req_ready),
        .req_write(req_write), .req_sram_id(req_sram_id), .req_chunk_id(req_chunk_id),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(g0_rsp_valid),
        .rsp_ready(1'b1), .rsp_rdata(g0_rsp_rdata),
        .rtap_srams_bist_command(g0_cmd), .rtap_srams_bist_data(g0_data),
        .srams_rtap_data(4'h0)
    );

    sram_bist_initiator #(.GAP_CYCLES(5)) dut_g5 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_g5), .req_ready(g5_req_ready),
        .req_write(req_write), .req_sram_id(req_sram_id), .req_chunk_id(req_chunk_id),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(g5_rsp_valid),
        .rsp_ready(1'b1), .rsp_rdata(g5_rsp_rdata),
        .rtap_srams_bist_command(g5_cmd), .rtap_srams_bist_data(g5_data),
        .srams_rtap_data(4'h0)
    );

    // Behavioural wrapper (SR_ID 0x2A, chunk 0x01, 64-bit words) and the reference image.
    logic [63:0]  mem     [0:4095] = '{12'h123: 64'hDEADBEEF, default: 64'h0};
    logic [63:0]  ref_mem [0:4095] = '{12'h123: 64'hDEADBEEF, default: 64'h0};
    logic [7:0]   m_id = 8'h0;
    logic [7:0]   m_ch = 8'h0;
    logic [15:0]  m_ad = 16'h0;
    logic [1:0]   m_mode = M_IDLE;
    logic         m_sel = 1'b0;
    int           m_dcnt = 0;
    logic [383:0] m_rbuf = '0;
    logic [319:0] m_wbuf = '0;
    logic [383:0] m_sh;

    always @(posedge clk) begin
        case (dut_cmd)
            C_ID: begin
                m_id   <= {m_id[3:0], dut_data};
                m_mode <= M_IDLE;
            end
            C_BSEL: m_ch <= {m_ch[3:0], dut_data};
            C_ADDR: m_ad <= {m_ad[11:0], dut_data};
            C_READ: begin
                m_rbuf <= (m_id == MY_ID && m_ch == MY_CH) ? {320'h0, mem[m_ad[11:0]]} : 384'h0;
                m_mode <= M_RD;
                m_dcnt <= 0;
            end
            C_DATA: begin
                if (m_mode == M_RD) begin
                    m_dcnt <= m_dcnt + 1;
                end else if (m_mode != M_WR) begin
                    m_mode <= M_WR;
                    m_sel  <= (m_id == MY_ID && m_ch == MY_CH);
                    m_dcnt <= 1;
                    m_wbuf <= {316'h0, dut_data};
                end else begin
                    m_dcnt <= m_dcnt + 1;
                    m_wbuf <= {m_wbuf[315:0], dut_data};
                end
            end
            default: begin
                if (m_mode == M_WR) begin
                    if (m_dcnt == 80 && m_sel) mem[m_ad[11:0]] <= m_wbuf[63:0];
                    m_mode <= M_IDLE;
                end else if (m_mode == M_RD && m_dcnt != 0) begin
                    m_mode <= M_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        m_sh            = m_rbuf >> (380 - 4 * m_dcnt);
        srams_rtap_data = (m_mode == M_RD && dut_cmd == C_DATA && m_dcnt < 96) ? m_sh[3:0] : 4'h0;
    end

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {command, nibble} in cycle T+n of a transaction accepted in cycle T.
    function automatic logic [6:0] exp_bus(input int n, input logic wr, input logic [7:0] id,
                                           input logic [7:0] ch, input logic [15:0] ad,
                                           input logic [319:0] wd);
        logic [319:0] sh;
        if (n >= 1 && n <= 2) return {C_ID, 4'(id >> (4 * (2 - n)))};
        if (n >= 3 && n <= 4) return {C_BSEL, 4'(ch >> (4 * (4 - n)))};
        if (n >= 5 && n <= 8) return {C_ADDR, 4'(ad >> (4 * (8 - n)))};
        if (wr) begin
            if (n >= 9 && n <= 88) begin
                sh = wd >> (4 * (79 - (n - 9)));
                return {C_DATA, sh[3:0]};
            end
        end else begin
            if (n == 9) return {C_READ, 4'h0};
            if (n >= 11 && n <= 106) return {C_DATA, 4'h0};
        end
        return {C_NOP, 4'h0};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom)};
        return v;
    endfunction

    task automatic run_req(input logic wr, input logic [7:0] id, input logic [7:0] ch,
                           input logic [15:0] ad, input logic [319:0] wd, input int hold);
        int n;
        int exp_n;
        logic hit;
        logic [383:0] exp_rd;
        hit    = (id == MY_ID) && (ch == MY_CH);
        exp_rd = (!wr && hit) ? {320'h0, ref_mem[ad[11:0]]} : 384'h0;
        exp_n  = 8 + (wr ? 80 : 98) + 2 + 1;
        check("req_ready_idle", 384'(req_ready), 384'(1'b1));
        req_write = wr; req_sram_id = id; req_chunk_id = ch; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_sram_id  = 8'($urandom);
        req_chunk_id = 8'($urandom);
        req_addr     = 16'($urandom);
        req_wdata    = rand320();
        n = 1;
        while (rsp_valid !== 1'b1 && n < 200) begin
            check("bus", 384'({dut_cmd, dut_data}), 384'(exp_bus(n, wr, id, ch, ad, wd)));
            check("req_ready_busy", 384'(req_ready), 384'(1'b0));
            @(posedge clk); #1;
            n++;
        end
        check("rsp_cycle", 384'(n), 384'(exp_n));
        check("rsp_rdata", rsp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("rsp_hold_valid", 384'(rsp_valid), 384'(1'b1));
            check("rsp_hold_data", rsp_rdata, exp_rd);
            check("req_ready_rsp", 384'(req_ready), 384'(1'b0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_done", 384'(rsp_valid), 384'(1'b0));
        check("req_ready_after", 384'(req_ready), 384'(1'b1));
        if (wr && hit) ref_mem[ad[11:0]] = wd[63:0];
    endtask

    initial begin
        logic [319:0] wd;
        logic [15:0]  ad;
        logic [7:0]   ch;
        logic         seen;
        int           n, r0, r5, l0, l5;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", 384'(dut_cmd), 384'(C_NOP));
        check("rst_data", 384'(dut_data), 384'(4'h0));
        check("rst_rsp_valid", 384'(rsp_valid), 384'(1'b0));
        check("rst_rsp_rdata", rsp_rdata, 384'h0);
        check("rst_req_ready", 384'(req_ready), 384'(1'b1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed read of the preloaded word, then write/read-back.
        run_req(1'b0, MY_ID, MY_CH, 16'h0123, '0, 0);
        wd = rand320();
        wd[63:0] = 64'h0123456789ABCDEF;
        run_req(1'b1, MY_ID, MY_CH, 16'h0007, wd, 0);
        run_req(1'b0, MY_ID, MY_CH, 16'h0007, '0, 0);
        check("readback_word", {320'h0, ref_mem[12'h007]}, {320'h0, 64'h0123456789ABCDEF});

        // Non-matching target and a held-off response.
        run_req(1'b0, 8'h55, MY_CH, 16'h0123, '0, 0);
        run_req(1'b0, MY_ID, MY_CH, 16'h0123, '0, 10);

        // Write aborted by reset in cycle T+50.
        wd = rand320();
        req_write = 1'b1; req_sram_id = MY_ID; req_chunk_id = MY_CH; req_addr = 16'h0007;
        req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (n < 50) begin
            check("abort_bus", 384'({dut_cmd, dut_data}), 384'(exp_bus(n, 1'b1, MY_ID, MY_CH, 16'h0007, wd)));
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_cmd", 384'({dut_cmd, dut_data}), 384'({C_NOP, 4'h0}));
        check("abort_rsp_valid", 384'(rsp_valid), 384'(1'b0));
        check("abort_idle", 384'(req_ready), 384'(1'b1));
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (120) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_rsp", 384'(seen), 384'(1'b0));
        run_req(1'b0, MY_ID, MY_CH, 16'h0007, '0, 0);

        // Randomised traffic against the reference image.
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 2))
                0:       ad = 16'h0007;
                1:       ad = 16'h0123;
                default: ad = 16'h0040 + 16'($urandom_range(0, 15));
            endcase
            ch = ($urandom_range(0, 3) == 0) ? 8'h02 : MY_CH;
            run_req(1'($urandom), MY_ID, ch, ad, rand320(), $urandom_range(0, 3));
        end

        // Gap length on the GAP_CYCLES=0 and GAP_CYCLES=5 instances.
        wd = rand320();
        req_write = 1'b1; req_sram_id = MY_ID; req_chunk_id = MY_CH; req_addr = 16'h0011;
        req_wdata = wd; req_valid_g0 = 1'b1; req_valid_g5 = 1'b1;
        @(posedge clk); #1;
        req_valid_g0 = 1'b0; req_valid_g5 = 1'b0;
        n = 1; r0 = 0; r5 = 0; l0 = 0; l5 = 0;
        while ((r0 == 0 || r5 == 0) && n < 200) begin
            if (g0_cmd == C_DATA) l0 = n;
            if (g5_cmd == C_DATA) l5 = n;
            if (g0_rsp_valid === 1'b1 && r0 == 0) r0 = n;
            if (g5_rsp_valid === 1'b1 && r5 == 0) r5 = n;
            @(posedge clk); #1;
            n++;
        end
        check("g0_last_data", 384'(l0), 384'(88));
        check("g5_last_data", 384'(l5), 384'(88));
        check("g0_rsp_cycle", 384'(r0), 384'(88 + 2 + 1));
        check("g5_rsp_cycle", 384'(r5), 384'(88 + 5 + 1));
        @(posedge clk); #1;
        check("g0_idle", 384'(g0_req_ready), 384'(1'b1));
        check("g5_idle", 384'(g5_req_ready), 384'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
